// File: rtl/nios_blink_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two Avalon-MM
// pipelined masters, with per-master grant lock and tagged read-data return.
module nios_blink_mem_arbiter #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BE_W        = DATA_W / 8,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic                   last_grant, last_grant_nxt;
  logic                   req0, req1;
  logic                   gnt0, gnt1;
  logic                   push_valid, push_id;
  logic [MEM_LATENCY-1:0] tag_valid, tag_id;
  logic                   ret_valid, ret_id;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Grant selection and lock tracking; grant is combinational in the request cycle
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 && req1) begin
          gnt0 = last_grant;
          gnt1 = ~last_grant;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
        if (gnt0) begin
          last_grant_nxt = 1'b0;
          if (m0_lock) state_nxt = LOCK0;
        end else if (gnt1) begin
          last_grant_nxt = 1'b1;
          if (m1_lock) state_nxt = LOCK1;
        end
      end
      LOCK0: begin
        gnt0 = req0;
        if (req0) last_grant_nxt = 1'b0;
        if (!m0_lock) state_nxt = IDLE;
      end
      LOCK1: begin
        gnt1 = req1;
        if (req1) last_grant_nxt = 1'b1;
        if (!m1_lock) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!reset_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  assign mem_chipselect = gnt0 | gnt1;
  assign mem_clken      = reset_n;
  assign mem_address    = gnt1 ? m1_address    : m0_address;
  assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
  assign mem_write      = (gnt0 & m0_write) | (gnt1 & m1_write);

  // Read+write together counts as a write, so only pure reads are tagged
  assign push_valid = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);
  assign push_id    = gnt1 & push_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid <= MEM_LATENCY'({tag_valid, push_valid});
      tag_id    <= MEM_LATENCY'({tag_id, push_id});
    end
  end

  assign ret_valid = tag_valid[MEM_LATENCY-1];
  assign ret_id    = tag_id[MEM_LATENCY-1];

  assign m0_readdatavalid = ret_valid & ~ret_id;
  assign m1_readdatavalid = ret_valid &  ret_id;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

endmodule

// File: tb/tb_nios_blink_mem_arbiter.sv
// Bench for nios_blink_mem_arbiter: behavioural RAM plus a rule-level reference
// model (winner prediction, ideal memory, queue of due read returns).
module tb_nios_blink_mem_arbiter;
  localparam int unsigned ADDR_W      = 13;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BE_W        = 4;
  localparam int unsigned MEM_LATENCY = 1;
  localparam int unsigned DEPTH       = 5120;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
  logic [BE_W-1:0]   m0_byteenable = '0, m1_byteenable = '0;
  logic              m0_read = 1'b0, m1_read = 1'b0;
  logic              m0_write = 1'b0, m1_write = 1'b0;
  logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0;
  logic              m0_lock = 1'b0, m1_lock = 1'b0;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata, mem_readdata;

  always #5 clk = ~clk;

  nios_blink_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MEM_LATENCY(MEM_LATENCY)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // Environment RAM driven only by the DUT's mem_* port
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] rd_pipe [MEM_LATENCY];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < int'(BE_W); b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
      end else begin
        rd_pipe[0] <= ram[mem_address];
      end
    end
    for (int i = 1; i < int'(MEM_LATENCY); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_readdata = rd_pipe[MEM_LATENCY-1];

  // Reference model state
  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } ret_t;
  ret_t        rq[$];
  logic [31:0] ref_mem [DEPTH];
  int          lock_owner = -1;
  int          last_win = 1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cnt_rv0 = 0, cnt_rv1 = 0;
  logic [31:0] last_rd0 = '0, last_rd1 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic preload(input int addr, input logic [31:0] data);
    ram[addr]     = data;
    ref_mem[addr] = data;
  endtask

  task automatic set_m(input int n, input logic rd, input logic wr, input logic lk,
                       input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] be,
                       input logic [DATA_W-1:0] wd);
    if (n == 0) begin
      m0_read = rd; m0_write = wr; m0_lock = lk;
      m0_address = a; m0_byteenable = be; m0_writedata = wd;
    end else begin
      m1_read = rd; m1_write = wr; m1_lock = lk;
      m1_address = a; m1_byteenable = be; m1_writedata = wd;
    end
  endtask

  task automatic idle_all();
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  function automatic int predict();
    bit r0, r1;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (!reset_n) return -1;
    if (lock_owner == 0) return r0 ? 0 : -1;
    if (lock_owner == 1) return r1 ? 1 : -1;
    if (r0 && r1) return (last_win == 1) ? 0 : 1;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // One clock: check outputs mid-cycle against the model, then advance the model
  task automatic tick();
    int              win;
    bit              ev0, ev1;
    logic [31:0]     ed0, ed1;
    logic            wr, lk;
    logic [ADDR_W-1:0] a;
    logic [BE_W-1:0] be;
    logic [31:0]     wd;
    #1;
    if (!reset_n) begin
      rq.delete();
      lock_owner = -1;
      last_win   = 1;
    end
    win = predict();
    ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].id == 0) begin ev0 = 1'b1; ed0 = rq[0].data; end
      else begin ev1 = 1'b1; ed1 = rq[0].data; end
      void'(rq.pop_front());
    end
    chk("m0_waitrequest", 32'(m0_waitrequest), 32'(win != 0));
    chk("m1_waitrequest", 32'(m1_waitrequest), 32'(win != 1));
    chk("mem_clken", 32'(mem_clken), 32'(reset_n));
    chk("mem_chipselect", 32'(mem_chipselect), 32'(win >= 0));
    if (win >= 0) begin
      wr = (win == 0) ? m0_write      : m1_write;
      lk = (win == 0) ? m0_lock       : m1_lock;
      a  = (win == 0) ? m0_address    : m1_address;
      be = (win == 0) ? m0_byteenable : m1_byteenable;
      wd = (win == 0) ? m0_writedata  : m1_writedata;
      chk("mem_address", 32'(mem_address), 32'(a));
      chk("mem_write", 32'(mem_write), 32'(wr));
      chk("mem_byteenable", 32'(mem_byteenable), 32'(be));
      if (wr) chk("mem_writedata", mem_writedata, wd);
    end else begin
      chk("mem_write_idle", 32'(mem_write), 32'd0);
    end
    chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(ev0));
    chk("m0_readdata", m0_readdata, ed0);
    chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(ev1));
    chk("m1_readdata", m1_readdata, ed1);
    if (m0_readdatavalid === 1'b1) begin cnt_rv0++; last_rd0 = m0_readdata; end
    if (m1_readdatavalid === 1'b1) begin cnt_rv1++; last_rd1 = m1_readdata; end

    if (win >= 0) begin
      if (wr) begin
        for (int b = 0; b < int'(BE_W); b++)
          if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
      end else begin
        rq.push_back('{cyc + int'(MEM_LATENCY), win, ref_mem[a]});
      end
      last_win   = win;
      lock_owner = lk ? win : -1;
    end else if (lock_owner == 0 && !m0_lock) begin
      lock_owner = -1;
    end else if (lock_owner == 1 && !m1_lock) begin
      lock_owner = -1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int r;
    logic rd, wr, lk;
    for (int i = 0; i < int'(DEPTH); i++) preload(i, $urandom);
    idle_all();
    @(negedge clk);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Lone m0 read returns after MEM_LATENCY cycles
    preload(16, 32'hDEADBEEF);
    cnt_rv0 = 0; cnt_rv1 = 0;
    set_m(0, 1'b1, 1'b0, 1'b0, 13'h0010, 4'hF, '0);
    tick();
    idle_all();
    repeat (2) tick();
    chk("t1_data", last_rd0, 32'hDEADBEEF);
    chk("t1_cnt0", 32'(cnt_rv0), 32'd1);
    chk("t1_cnt1", 32'(cnt_rv1), 32'd0);

    // Continuous contention alternates grants starting with m0
    do_reset();
    cnt_rv0 = 0; cnt_rv1 = 0;
    for (int i = 0; i < 8; i++) begin
      set_m(0, 1'b1, 1'b0, 1'b0, 13'(32'h20 + i), 4'hF, '0);
      set_m(1, 1'b1, 1'b0, 1'b0, 13'(32'h40 + i), 4'hF, '0);
      tick();
    end
    idle_all();
    repeat (3) tick();
    chk("t2_cnt0", 32'(cnt_rv0), 32'd4);
    chk("t2_cnt1", 32'(cnt_rv1), 32'd4);

    // Partial byte-enable write then readback
    preload(32'h100, 32'hFFFFFFFF);
    set_m(1, 1'b0, 1'b1, 1'b0, 13'h0100, 4'b0011, 32'h12345678);
    tick();
    idle_all();
    set_m(0, 1'b1, 1'b0, 1'b0, 13'h0100, 4'hF, '0);
    tick();
    idle_all();
    repeat (2) tick();
    chk("t3_data", last_rd0, 32'hFFFF5678);

    // m1 locked for three writes while m0 keeps reading
    for (int i = 0; i < 3; i++) begin
      set_m(0, 1'b1, 1'b0, 1'b0, 13'h0300, 4'hF, '0);
      set_m(1, 1'b0, 1'b1, (i < 2), 13'(32'h200 + i), 4'hF, 32'hC0DE0000 + 32'(i));
      #1;
      chk("t4_m0_wait", 32'(m0_waitrequest), 32'd1);
      chk("t4_m1_wait", 32'(m1_waitrequest), 32'd0);
      tick();
    end
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("t4_m0_granted", 32'(m0_waitrequest), 32'd0);
    tick();
    idle_all();
    repeat (2) tick();

    // Read and write together: write only, no return
    cnt_rv0 = 0;
    set_m(0, 1'b1, 1'b1, 1'b0, 13'h0004, 4'hF, 32'hA5A55A5A);
    tick();
    idle_all();
    repeat (2) tick();
    chk("t5_no_rdv", 32'(cnt_rv0), 32'd0);
    set_m(0, 1'b1, 1'b0, 1'b0, 13'h0004, 4'hF, '0);
    tick();
    idle_all();
    repeat (2) tick();
    chk("t5_data", last_rd0, 32'hA5A55A5A);

    // Reset with reads in flight
    for (int i = 0; i < 2; i++) begin
      set_m(0, 1'b1, 1'b0, 1'b0, 13'h0010, 4'hF, '0);
      set_m(1, 1'b1, 1'b0, 1'b0, 13'h0100, 4'hF, '0);
      tick();
    end
    reset_n = 1'b0;
    #1;
    chk("t6_rst_m0_wait", 32'(m0_waitrequest), 32'd1);
    chk("t6_rst_cs", 32'(mem_chipselect), 32'd0);
    chk("t6_rst_clken", 32'(mem_clken), 32'd0);
    tick();
    reset_n = 1'b1;
    cnt_rv0 = 0; cnt_rv1 = 0;
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_m(0, 1'b1, 1'b0, 1'b0, 13'h0004, 4'hF, '0);
    tick();
    idle_all();
    repeat (2) tick();
    chk("t6_cnt0", 32'(cnt_rv0), 32'd1);
    chk("t6_cnt1", 32'(cnt_rv1), 32'd0);
    chk("t6_data", last_rd0, 32'hA5A55A5A);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) begin
        r  = int'($urandom_range(0, 9));
        rd = (r < 4) || (r == 7);
        wr = (r >= 4) && (r <= 7);
        lk = ($urandom_range(0, 4) == 0);
        set_m(n, rd, wr, lk, 13'($urandom_range(0, 63)), 4'($urandom), $urandom);
      end
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        tick();
      end
    end
    idle_all();
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
